// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit controller.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_SB:   be = 4'b0001 << addr_lo;
            F3_SH:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3)
            F3_SB:   lanes = {4{wdata[7:0]}};
            F3_SH:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_LH, F3_LHU: mis = addr_lo[0];
            F3_LW:         mis = (addr_lo != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data lane extraction with sign/zero extension.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Byte lane selection by low address bits
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Width and signedness selection
    always_comb begin
        data = 32'h0000_0000;
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  data = {24'h00_0000, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LHU:  data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single-outstanding word bus, lane alignment, watchdog.
// Optional build macro MISALIGN_TRAP_EN reports misaligned H/W accesses as errors without bus activity.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic TO_EN = (TIMEOUT != 0);

    lsu_state_t        state_r, state_next_s;
    logic              we_r;
    logic [2:0]        f3_r;
    logic [1:0]        addr_lo_r;
    logic [ADDR_W-3:0] word_addr_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [31:0]       data_r;
    logic              err_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              accept_s;
    logic              misalign_s;
    logic              timeout_s;
    logic              to_fire_s;
    logic [31:0]       load_data_s;

    assign accept_s  = req_valid & (state_r == IDLE);
    assign timeout_s = TO_EN & (cnt_r == TO_LAST);
    assign to_fire_s = timeout_s & (((state_r == REQ) & ~mem_gnt) | ((state_r == WAIT) & ~mem_rvalid));

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    lsu_load_align u_align (
        .funct3  (f3_r),
        .addr_lo (addr_lo_r),
        .rdata   (mem_rdata),
        .data    (load_data_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a grant or rvalid arriving in the timeout cycle still wins
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = misalign_s ? RESP : REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_next_s = we_r ? RESP : WAIT;
                end else if (timeout_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Moore outputs; bus fields are forced to zero whenever no request is driven
    always_comb begin
        req_ready = 1'b0;
        mem_req   = 1'b0;
        rsp_valid = 1'b0;
        case (state_r)
            IDLE:    req_ready = 1'b1;
            REQ:     mem_req   = 1'b1;
            WAIT:    mem_req   = 1'b0;
            RESP:    rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
        mem_we    = (state_r == REQ) & we_r;
        mem_addr  = (state_r == REQ) ? {word_addr_r, 2'b00} : {ADDR_W{1'b0}};
        mem_be    = (state_r == REQ) ? be_r : 4'b0000;
        mem_wdata = (state_r == REQ) ? wdata_r : 32'h0000_0000;
        rsp_rdata = (state_r == RESP) ? data_r : 32'h0000_0000;
        rsp_err   = (state_r == RESP) & err_r;
    end

    // Request capture, load data capture and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r        <= 1'b0;
            f3_r        <= 3'b000;
            addr_lo_r   <= 2'b00;
            word_addr_r <= {(ADDR_W-2){1'b0}};
            be_r        <= 4'b0000;
            wdata_r     <= 32'h0000_0000;
            data_r      <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else if (accept_s) begin
            we_r        <= req_we;
            f3_r        <= req_funct3;
            addr_lo_r   <= req_addr[1:0];
            word_addr_r <= req_addr[ADDR_W-1:2];
            be_r        <= req_we ? be_for(req_funct3, req_addr[1:0]) : 4'b1111;
            wdata_r     <= req_we ? store_lanes(req_funct3, req_wdata) : 32'h0000_0000;
            data_r      <= 32'h0000_0000;
            err_r       <= misalign_s;
        end else if ((state_r == WAIT) && mem_rvalid) begin
            data_r      <= load_data_s;
        end else if (to_fire_s) begin
            err_r       <= 1'b1;
        end
    end

    // Watchdog counter, restarted in IDLE and on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == IDLE) || ((state_r == REQ) && mem_gnt)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (((state_r == REQ) || (state_r == WAIT)) && !timeout_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; a second instance with TIMEOUT=4 covers the watchdog.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid_to = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        req_ready, mem_req, mem_we, rsp_valid, rsp_err;
    logic [31:0] mem_addr, mem_wdata, rsp_rdata;
    logic [3:0]  mem_be;
    logic        t_req_ready, t_mem_req, t_mem_we, t_rsp_valid, t_rsp_err;
    logic [31:0] t_mem_addr, t_mem_wdata, t_rsp_rdata;
    logic [3:0]  t_mem_be;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT(256)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_to), .req_ready(t_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
        .mem_wdata(t_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Zero-wait load: accept, grant in first REQ cycle, rvalid in WAIT; returns in the RESP cycle
    task automatic zw_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr);
        issue(1'b0, f3, addr, 32'h0);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        check({tag, "_req"}, {31'h0, mem_req}, 32'h1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_be"}, {28'h0, mem_be}, 32'hF);
        check({tag, "_we"}, {31'h0, mem_we}, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({tag, "_wait_req"}, {31'h0, mem_req}, 32'h0);
        check({tag, "_wait_rsp"}, {31'h0, rsp_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        // LB sign-extended from byte 3, rsp at T+3
        zw_load("lb", F3_LB, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100);
        check("lb_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
        check("lb_err", {31'h0, rsp_err}, 32'h0);
        tick();
        check("lb_pulse_end", {31'h0, rsp_valid}, 32'h0);
        check("lb_idle_ready", {31'h0, req_ready}, 32'h1);

        zw_load("lhu", F3_LHU, 32'h0000_0102, 32'hBEEF_1234, 32'h0000_0100);
        check("lhu_rdata", rsp_rdata, 32'h0000_BEEF);
        tick();

        zw_load("lh", F3_LH, 32'h0000_0100, 32'h0000_8001, 32'h0000_0100);
        check("lh_rdata", rsp_rdata, 32'hFFFF_8001);
        tick();

        // SB with grant withheld for three cycles
        issue(1'b1, F3_SB, 32'h0000_0201, 32'h0000_00AB);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sb_req", {31'h0, mem_req}, 32'h1);
            check("sb_we", {31'h0, mem_we}, 32'h1);
            check("sb_addr", mem_addr, 32'h0000_0200);
            check("sb_be", {28'h0, mem_be}, 32'h2);
            check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
            tick();
        end
        check("sb_req_hold", {31'h0, mem_req}, 32'h1);
        check("sb_no_early_rsp", {31'h0, rsp_valid}, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sb_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("sb_rdata", rsp_rdata, 32'h0);
        check("sb_err", {31'h0, rsp_err}, 32'h0);
        check("sb_req_drop", {31'h0, mem_req}, 32'h0);
        tick();
        check("sb_pulse_end", {31'h0, rsp_valid}, 32'h0);

        // SH zero-wait: rsp at T+2
        issue(1'b1, F3_SH, 32'h0000_0202, 32'hFFFF_1234);
        tick();
        req_valid = 1'b0;
        check("sh_be", {28'h0, mem_be}, 32'hC);
        check("sh_wdata", mem_wdata, 32'h1234_1234);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sh_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        tick();

        // Watchdog on the TIMEOUT=4 instance
        req_valid_to = 1'b1;
        req_we       = 1'b0;
        req_funct3   = F3_LW;
        req_addr     = 32'h0000_0304;
        check("to_ready", {31'h0, t_req_ready}, 32'h1);
        tick();
        req_valid_to = 1'b0;
        check("to_addr", t_mem_addr, 32'h0000_0304);
        check("to_be", {28'h0, t_mem_be}, 32'hF);
        check("to_we", {31'h0, t_mem_we}, 32'h0);
        check("to_wdata", t_mem_wdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("to_req_held", {31'h0, t_mem_req}, 32'h1);
            check("to_no_rsp", {31'h0, t_rsp_valid}, 32'h0);
            tick();
        end
        check("to_rsp_valid", {31'h0, t_rsp_valid}, 32'h1);
        check("to_rsp_err", {31'h0, t_rsp_err}, 32'h1);
        check("to_rsp_rdata", t_rsp_rdata, 32'h0);
        check("to_req_drop", {31'h0, t_mem_req}, 32'h0);
        tick();
        check("to_pulse_end", {31'h0, t_rsp_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        check("to_stale_rvalid", {31'h0, t_rsp_valid}, 32'h0);
        check("idle_stale_rvalid", {31'h0, rsp_valid}, 32'h0);
        tick();
        check("to_stale_rvalid2", {31'h0, t_rsp_valid}, 32'h0);
        check("to_back_idle", {31'h0, t_req_ready}, 32'h1);

        // Misaligned LW
`ifdef MISALIGN_TRAP_EN
        issue(1'b0, F3_LW, 32'h0000_0102, 32'h0);
        tick();
        req_valid = 1'b0;
        check("mis_no_req", {31'h0, mem_req}, 32'h0);
        check("mis_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("mis_err", {31'h0, rsp_err}, 32'h1);
        check("mis_rdata", rsp_rdata, 32'h0);
        tick();
        check("mis_no_req2", {31'h0, mem_req}, 32'h0);
        check("mis_idle", {31'h0, req_ready}, 32'h1);
`else
        zw_load("mis", F3_LW, 32'h0000_0102, 32'hCAFE_F00D, 32'h0000_0100);
        check("mis_rdata", rsp_rdata, 32'hCAFE_F00D);
        check("mis_err", {31'h0, rsp_err}, 32'h0);
        tick();
`endif

        // Asynchronous reset while a request is on the bus
        issue(1'b0, F3_LBU, 32'h0000_0101, 32'h0);
        tick();
        req_valid = 1'b0;
        check("ar_req_before", {31'h0, mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req_drop", {31'h0, mem_req}, 32'h0);
        check("ar_ready", {31'h0, req_ready}, 32'h1);
        check("ar_addr", mem_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        zw_load("post_rst", F3_LBU, 32'h0000_0101, 32'h0000_9A00, 32'h0000_0100);
        check("post_rst_valid", {31'h0, rsp_valid}, 32'h1);
        check("post_rst_rdata", rsp_rdata, 32'h0000_009A);
        check("post_rst_err", {31'h0, rsp_err}, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
